// File: rtl/timing_sequencer_if.sv
// ---------------------------------------------------------------------------
// timing_sequencer_if
//   Groups the decoder-facing strobes, interrupt lines and the sequencer
//   outputs into one bundle.
//
//   Flow control: rdy is a plain advance/stall qualifier, not a two-way
//   handshake. The sequencer advances on a clock edge where rdy=1. On an
//   edge where rdy=0, every register holds and all strobes are ignored.
//   The only exception is nmi, which is sampled on every edge regardless
//   of rdy.
//
//   master : drives the inputs (decoder / environment side)
//   slave  : the sequencer itself
//   nmiPend is a debug view of the latched NMI edge.
// ---------------------------------------------------------------------------
interface timing_sequencer_if #(
  parameter int INSTR_W = 6,
  parameter int ADDR_W  = 4,
  parameter int T_W     = 3
);
  logic               rdy;
  logic               noAddressing;
  logic               getInstruction;
  logic               endAddressing;
  logic               irq;
  logic               irqMask;
  logic               nmi;
  logic [INSTR_W-1:0] decodedInstruction;
  logic [ADDR_W-1:0]  decodedAddress;
  logic [INSTR_W-1:0] currentInstruction;
  logic [ADDR_W-1:0]  currentAddress;
  logic [T_W-1:0]     timeState;
  logic [1:0]         mode;
  logic               intSource;
  logic               timeout;
  logic               nmiPend;

  modport master (
    output rdy, noAddressing, getInstruction, endAddressing,
    output irq, irqMask, nmi, decodedInstruction, decodedAddress,
    input  currentInstruction, currentAddress, timeState, mode,
    input  intSource, timeout, nmiPend
  );

  modport slave (
    input  rdy, noAddressing, getInstruction, endAddressing,
    input  irq, irqMask, nmi, decodedInstruction, decodedAddress,
    output currentInstruction, currentAddress, timeState, mode,
    output intSource, timeout, nmiPend
  );
endinterface

// File: rtl/timing_sequencer.sv
// ---------------------------------------------------------------------------
// timing_sequencer
//   Instruction-timing state machine. It counts T-states and tracks the
//   phase (ADDRESS / INSTRUCTION / INTERRUPT). It latches the opcode and
//   addressing-mode codes from the decoder.
//
//   Interrupts are taken only at instruction boundaries:
//     - NMI is rising-edge sensitive.
//     - IRQ is a level, gated by irqMask.
//   An overrun past MAX_T forces a restart with a one-cycle timeout pulse.
//
// Ports
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : timing_sequencer_if.slave
//          inputs  : rdy, noAddressing, getInstruction, endAddressing,
//                    irq, irqMask, nmi, decodedInstruction, decodedAddress
//          outputs : currentInstruction, currentAddress, timeState, mode,
//                    intSource, timeout, nmiPend (debug)
// ---------------------------------------------------------------------------
module timing_sequencer #(
  parameter int                   INSTR_W   = 6,
  parameter int                   ADDR_W    = 4,
  parameter int                   T_W       = 3,
  parameter int                   MAX_T     = 6,
  parameter logic [INSTR_W-1:0]   INT_INSTR = 6'h3F
) (
  input logic                clk,
  input logic                rst,
  timing_sequencer_if.slave  bus
);

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_INSTR = 2'd1;
  localparam logic [1:0] MODE_INT   = 2'd2;

  localparam logic [T_W-1:0] T_LAST = T_W'(MAX_T);

  logic [1:0]         mode_q,     mode_d;
  logic [T_W-1:0]     t_q,        t_d;
  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;
  logic               src_q,      src_d;
  logic               timeout_q,  timeout_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_pend_q, nmi_pend_d;

  logic               nmi_edge;
  logic               int_req;
  logic [1:0]         mode_eff;

  assign nmi_edge = bus.nmi & ~nmi_prev_q;
  assign int_req  = nmi_pend_q | (bus.irq & ~bus.irqMask);

  // The unused encoding 3 behaves as ADDRESS so the machine recovers.
  assign mode_eff = (mode_q == 2'd3) ? MODE_ADDR : mode_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_ADDR;
      t_q        <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      src_q      <= 1'b0;
      timeout_q  <= 1'b0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      t_q        <= t_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      timeout_q  <= timeout_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    mode_d     = mode_q;
    t_d        = t_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    src_d      = src_q;
    timeout_d  = 1'b0;
    // nmi history keeps running through stalls so no edge is missed.
    nmi_prev_d = bus.nmi;
    nmi_pend_d = nmi_pend_q | nmi_edge;

    if (bus.rdy) begin
      if (bus.getInstruction && (mode_eff != MODE_INT) && int_req) begin
        // Enter the interrupt sequence. NMI has priority over IRQ.
        // An edge arriving in this same cycle re-arms nmiPend.
        mode_d     = MODE_INT;
        t_d        = '0;
        instr_d    = INT_INSTR;
        addr_d     = '0;
        src_d      = nmi_pend_q;
        nmi_pend_d = nmi_pend_q ? nmi_edge : (nmi_pend_q | nmi_edge);
      end else if (bus.getInstruction && (mode_eff == MODE_INT)) begin
        // Leaving an interrupt sequence always fetches a real
        // instruction; interrupts are not chained back to back.
        mode_d  = MODE_ADDR;
        t_d     = '0;
        instr_d = bus.decodedInstruction;
        addr_d  = bus.decodedAddress;
      end else if ((bus.endAddressing && (mode_eff == MODE_ADDR)) ||
                   (bus.noAddressing && bus.getInstruction)) begin
        mode_d = MODE_INSTR;
        t_d    = '0;
        if (bus.getInstruction) begin
          instr_d = bus.decodedInstruction;
          addr_d  = bus.decodedAddress;
        end
      end else if (bus.getInstruction) begin
        mode_d  = MODE_ADDR;
        t_d     = '0;
        instr_d = bus.decodedInstruction;
        addr_d  = bus.decodedAddress;
      end else if (t_q >= T_LAST) begin
        // Runaway sequence: restart at ADDRESS and keep the latched codes.
        timeout_d = 1'b1;
        mode_d    = MODE_ADDR;
        t_d       = '0;
      end else begin
        mode_d = mode_eff;
        t_d    = t_q + T_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.currentInstruction = instr_q;
    bus.currentAddress     = addr_q;
    bus.timeState          = t_q;
    bus.mode               = mode_q;
    bus.intSource          = src_q;
    bus.timeout            = timeout_q;
    bus.nmiPend            = nmi_pend_q;
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timing_sequencer
//   Directed bench for timing_sequencer.
//   Each record holds one cycle of inputs and the outputs expected after
//   that clock edge. The expected values were worked out by hand from the
//   behaviour description.
// ---------------------------------------------------------------------------
module tb_timing_sequencer;

  localparam logic [7:0] R   = 8'h80;
  localparam logic [7:0] RDY = 8'h40;
  localparam logic [7:0] NOA = 8'h20;
  localparam logic [7:0] GI  = 8'h10;
  localparam logic [7:0] EA  = 8'h08;
  localparam logic [7:0] IRQ = 8'h04;
  localparam logic [7:0] MSK = 8'h02;
  localparam logic [7:0] NMI = 8'h01;

  typedef struct {
    logic [7:0] ctl;  // {rst, rdy, noAddressing, getInstruction, endAddressing, irq, irqMask, nmi}
    logic [5:0] di;
    logic [3:0] da;
    logic [5:0] ci;
    logic [3:0] ca;
    logic [2:0] ts;
    logic [1:0] md;
    logic       src;
    logic       to;
    logic       pend;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  timing_sequencer_if bus ();

  timing_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // -------------------------------------------------------------------------
  // Clock and initial reset level
  // -------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst                    = 1'b1;
    bus.rdy                = 1'b0;
    bus.noAddressing       = 1'b0;
    bus.getInstruction     = 1'b0;
    bus.endAddressing      = 1'b0;
    bus.irq                = 1'b0;
    bus.irqMask            = 1'b0;
    bus.nmi                = 1'b0;
    bus.decodedInstruction = '0;
    bus.decodedAddress     = '0;
  end

  function automatic vec_t mk(input logic [7:0] ctl, input logic [5:0] di,
                              input logic [3:0] da, input logic [5:0] ci,
                              input logic [3:0] ca, input int ts, input int md,
                              input logic src, input logic to, input logic pend);
    vec_t v;
    v.ctl  = ctl;
    v.di   = di;
    v.da   = da;
    v.ci   = ci;
    v.ca   = ca;
    v.ts   = 3'(ts);
    v.md   = 2'(md);
    v.src  = src;
    v.to   = to;
    v.pend = pend;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Driver + scoreboard check: drive one cycle, compare after the edge
  // -------------------------------------------------------------------------
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [17:0] got;
    logic [17:0] exp;
    rst                    = v.ctl[7];
    bus.rdy                = v.ctl[6];
    bus.noAddressing       = v.ctl[5];
    bus.getInstruction     = v.ctl[4];
    bus.endAddressing      = v.ctl[3];
    bus.irq                = v.ctl[2];
    bus.irqMask            = v.ctl[1];
    bus.nmi                = v.ctl[0];
    bus.decodedInstruction = v.di;
    bus.decodedAddress     = v.da;
    @(posedge clk);
    #1;
    got = {bus.currentInstruction, bus.currentAddress, bus.timeState,
           bus.mode, bus.intSource, bus.timeout, bus.nmiPend};
    exp = {v.ci, v.ca, v.ts, v.md, v.src, v.to, v.pend};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got ci=%h ca=%h t=%0d m=%0d src=%b to=%b pend=%b, want ci=%h ca=%h t=%0d m=%0d src=%b to=%b pend=%b",
               tag, idx, bus.currentInstruction, bus.currentAddress,
               bus.timeState, bus.mode, bus.intSource, bus.timeout, bus.nmiPend,
               v.ci, v.ca, v.ts, v.md, v.src, v.to, v.pend);
    end
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  vec_t tbl [38];

  initial begin
    checks = 0;
    errors = 0;

    //             ctl             di     da     ci     ca    t  m src to pend
    tbl[0]  = mk(R|RDY,          6'h00, 4'h0, 6'h00, 4'h0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 2, 0, 0, 0, 0);
    tbl[3]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 3, 0, 0, 0, 0);
    tbl[4]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 4, 0, 0, 0, 0);
    tbl[5]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 5, 0, 0, 0, 0);
    tbl[6]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 6, 0, 0, 0, 0);
    tbl[7]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(RDY,            6'h00, 4'h0, 6'h00, 4'h0, 2, 0, 0, 0, 0);
    tbl[10] = mk(RDY|GI,         6'h12, 4'h5, 6'h12, 4'h5, 0, 0, 0, 0, 0);
    tbl[11] = mk(RDY,            6'h00, 4'h0, 6'h12, 4'h5, 1, 0, 0, 0, 0);
    tbl[12] = mk(RDY,            6'h00, 4'h0, 6'h12, 4'h5, 2, 0, 0, 0, 0);
    tbl[13] = mk(RDY,            6'h00, 4'h0, 6'h12, 4'h5, 3, 0, 0, 0, 0);
    tbl[14] = mk(RDY|EA,         6'h00, 4'h0, 6'h12, 4'h5, 0, 1, 0, 0, 0);
    tbl[15] = mk(RDY|EA,         6'h00, 4'h0, 6'h12, 4'h5, 1, 1, 0, 0, 0);
    tbl[16] = mk(RDY|GI|IRQ,     6'h21, 4'h3, 6'h3F, 4'h0, 0, 2, 0, 0, 0);
    tbl[17] = mk(RDY|IRQ,        6'h00, 4'h0, 6'h3F, 4'h0, 1, 2, 0, 0, 0);
    tbl[18] = mk(RDY|GI|IRQ,     6'h21, 4'h3, 6'h21, 4'h3, 0, 0, 0, 0, 0);
    tbl[19] = mk(RDY|EA,         6'h00, 4'h0, 6'h21, 4'h3, 0, 1, 0, 0, 0);
    tbl[20] = mk(RDY|GI|IRQ|MSK, 6'h0A, 4'h7, 6'h0A, 4'h7, 0, 0, 0, 0, 0);
    tbl[21] = mk(RDY|NOA|GI,     6'h0B, 4'h1, 6'h0B, 4'h1, 0, 1, 0, 0, 0);
    tbl[22] = mk(RDY|NOA,        6'h00, 4'h0, 6'h0B, 4'h1, 1, 1, 0, 0, 0);
    tbl[23] = mk(RDY|NMI,        6'h00, 4'h0, 6'h0B, 4'h1, 2, 1, 0, 0, 1);
    tbl[24] = mk(RDY,            6'h00, 4'h0, 6'h0B, 4'h1, 3, 1, 0, 0, 1);
    tbl[25] = mk(RDY|GI|NMI,     6'h0C, 4'h2, 6'h3F, 4'h0, 0, 2, 1, 0, 1);
    tbl[26] = mk(RDY|GI,         6'h0D, 4'h8, 6'h0D, 4'h8, 0, 0, 1, 0, 1);
    tbl[27] = mk(RDY|GI,         6'h0E, 4'h9, 6'h3F, 4'h0, 0, 2, 1, 0, 0);
    tbl[28] = mk(RDY|GI,         6'h0F, 4'hA, 6'h0F, 4'hA, 0, 0, 1, 0, 0);
    tbl[29] = mk(RDY|EA,         6'h00, 4'h0, 6'h0F, 4'hA, 0, 1, 1, 0, 0);
    tbl[30] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 1, 1, 1, 0, 0);
    tbl[31] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 2, 1, 1, 0, 0);
    tbl[32] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 3, 1, 1, 0, 0);
    tbl[33] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 4, 1, 1, 0, 0);
    tbl[34] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 5, 1, 1, 0, 0);
    tbl[35] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 6, 1, 1, 0, 0);
    tbl[36] = mk(RDY|EA,         6'h00, 4'h0, 6'h0F, 4'hA, 0, 0, 1, 1, 0);
    tbl[37] = mk(RDY,            6'h00, 4'h0, 6'h0F, 4'hA, 1, 0, 1, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 38; i++) apply(tbl[i], "table", i);

    // NMI edge arriving while stalled at T3
    apply(mk(RDY,     6'h00, 4'h0, 6'h0F, 4'hA, 2, 0, 1, 0, 0), "nmi_stall", 0);
    apply(mk(RDY,     6'h00, 4'h0, 6'h0F, 4'hA, 3, 0, 1, 0, 0), "nmi_stall", 1);
    apply(mk(NMI,     6'h00, 4'h0, 6'h0F, 4'hA, 3, 0, 1, 0, 1), "nmi_stall", 2);
    for (int i = 0; i < 2; i++)
      apply(mk(8'h00, 6'h00, 4'h0, 6'h0F, 4'hA, 3, 0, 1, 0, 1), "nmi_hold", i);
    apply(mk(RDY,     6'h00, 4'h0, 6'h0F, 4'hA, 4, 0, 1, 0, 1), "nmi_seq", 0);
    apply(mk(RDY|GI,  6'h15, 4'h2, 6'h3F, 4'h0, 0, 2, 1, 0, 0), "nmi_seq", 1);
    apply(mk(RDY,     6'h00, 4'h0, 6'h3F, 4'h0, 1, 2, 1, 0, 0), "nmi_seq", 2);
    apply(mk(RDY|GI,  6'h16, 4'h4, 6'h16, 4'h4, 0, 0, 1, 0, 0), "nmi_seq", 3);
    apply(mk(RDY|GI,  6'h17, 4'h6, 6'h17, 4'h6, 0, 0, 1, 0, 0), "nmi_seq", 4);

    // Stall at T4 with getInstruction held
    for (int i = 1; i <= 4; i++)
      apply(mk(RDY, 6'h00, 4'h0, 6'h17, 4'h6, i, 0, 1, 0, 0), "stall_walk", i);
    for (int i = 0; i < 4; i++)
      apply(mk(GI,  6'h2A, 4'h9, 6'h17, 4'h6, 4, 0, 1, 0, 0), "stall_hold", i);
    apply(mk(RDY|GI, 6'h2A, 4'h9, 6'h2A, 4'h9, 0, 0, 1, 0, 0), "stall_release", 0);

    // Stall at MAX_T: no timeout until rdy returns
    for (int i = 1; i <= 6; i++)
      apply(mk(RDY, 6'h00, 4'h0, 6'h2A, 4'h9, i, 0, 1, 0, 0), "max_walk", i);
    for (int i = 0; i < 2; i++)
      apply(mk(8'h00, 6'h00, 4'h0, 6'h2A, 4'h9, 6, 0, 1, 0, 0), "max_hold", i);
    apply(mk(RDY, 6'h00, 4'h0, 6'h2A, 4'h9, 0, 0, 1, 1, 0), "max_timeout", 0);

    // Reset during an interrupt sequence with an NMI pending
    apply(mk(RDY|NMI, 6'h00, 4'h0, 6'h2A, 4'h9, 1, 0, 1, 0, 1), "mid_rst", 0);
    apply(mk(RDY|GI,  6'h05, 4'h1, 6'h3F, 4'h0, 0, 2, 1, 0, 0), "mid_rst", 1);
    apply(mk(RDY|NMI, 6'h00, 4'h0, 6'h3F, 4'h0, 1, 2, 1, 0, 1), "mid_rst", 2);
    apply(mk(RDY,     6'h00, 4'h0, 6'h3F, 4'h0, 2, 2, 1, 0, 1), "mid_rst", 3);
    apply(mk(RDY,     6'h00, 4'h0, 6'h3F, 4'h0, 3, 2, 1, 0, 1), "mid_rst", 4);
    apply(mk(R|GI|NMI, 6'h11, 4'h1, 6'h00, 4'h0, 0, 0, 0, 0, 0), "mid_rst", 5);
    apply(mk(RDY|GI,  6'h33, 4'h4, 6'h33, 4'h4, 0, 0, 0, 0, 0), "mid_rst", 6);
    apply(mk(RDY|GI,  6'h34, 4'h2, 6'h34, 4'h2, 0, 0, 0, 0, 0), "mid_rst", 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
- Parametrised successor to the core's instruction-timing state machine.
- Generates the T-state count and the ADDRESS / INSTRUCTION phase, and latches opcode and addressing-mode codes from the decoder.
- New behaviour:
  - RDY stall.
  - Interrupt injection (NMI edge, maskable IRQ level) at instruction boundaries, via a third INTERRUPT phase.
  - Runaway-sequence timeout.
- Sits between the instruction decoder and the control-signal ROM/decoder.

Parameters:
INSTR_W, 6, width of decodedInstruction/currentInstruction
ADDR_W, 4, width of decodedAddress/currentAddress
T_W, 3, width of timeState
MAX_T, 6, last legal T-state; must be < 2**T_W
INT_INSTR, 6'h3F, instruction code loaded when an interrupt sequence is entered (INSTR_W wide)

Ports:
clk  input  1  system clock; the block uses one clock
rst  input  1  reset; synchronous and active-high
rdy  input  1  1 = advance; 0 = stall, all state registers hold
noAddressing  input  1  current instruction needs no addressing phase
getInstruction  input  1  last cycle of current instruction / interrupt sequence
endAddressing  input  1  last cycle of addressing phase
irq  input  1  maskable interrupt request, level
irqMask  input  1  1 = irq ignored (I flag)
nmi  input  1  non-maskable interrupt, rising-edge sensitive
decodedInstruction  input  INSTR_W  opcode class from decoder
decodedAddress  input  ADDR_W  addressing mode from decoder
currentInstruction  output  INSTR_W  latched instruction code
currentAddress  output  ADDR_W  latched addressing mode
timeState  output  T_W  current T-state
mode  output  2  phase: 0 = ADDRESS, 1 = INSTRUCTION, 2 = INTERRUPT (3 unused)
intSource  output  1  valid in INTERRUPT mode; 1 = NMI, 0 = IRQ
timeout  output  1  one-cycle pulse when a sequence overran MAX_T

Behaviour:
- Reset (rst=1 at posedge): mode=0, timeState=0, currentInstruction=0, currentAddress=0, intSource=0, timeout=0, NMI edge latch=0, nmi history=0. rst overrides rdy and all strobes.
- NMI detect: nmi sampled every cycle, including rdy=0. Rising edge (nmi=1, previous sample 0) sets nmiPend. nmiPend clears only when an NMI sequence is entered.
- Pending interrupt: intReq = nmiPend | (irq & ~irqMask).
- rdy=0: timeState, mode, currentInstruction, currentAddress and intSource hold; timeout=0; strobes ignored.
- rdy=1, evaluated in priority order (one action per cycle). Every next-state update lands at the next posedge:
  1. getInstruction & mode!=2 & intReq:
     - mode=2, timeState=0, currentInstruction=INT_INSTR, currentAddress=0.
     - intSource=nmiPend; if nmiPend, clear nmiPend.
     - A new nmi edge arriving in this same cycle sets nmiPend again; set beats clear.
  2. getInstruction & mode==2:
     - mode=0, timeState=0, load decodedInstruction/decodedAddress.
     - No back-to-back interrupt: intReq is not checked here.
  3. endAddressing & mode==0, or noAddressing & getInstruction: mode=1, timeState=0.
  4. getInstruction (otherwise): mode=0, timeState=0.
  5. timeState==MAX_T with no strobe: timeout=1 for one cycle, mode=0, timeState=0; latched codes unchanged.
  6. Else: timeState increments by 1; mode holds.
- Code loading: currentInstruction/currentAddress load decoded values on any rdy=1 cycle with getInstruction, except rule 1, which loads INT_INSTR/0.
- Ignored strobes: endAddressing is ignored in mode 1 and mode 2.
- timeout: registered; it is 0 in every cycle not covered by rule 5.
- Mode 3: unreachable; if ever present, it is treated as mode 0 on the next rdy=1 cycle.
- Mid-operation reset: any state returns to reset values; a pending NMI is lost.
- Width rules: timeState is unsigned and never exceeds MAX_T; no wrap to 2**T_W.

Test Plan:
- Reset, then rdy=1 with no strobes for 8 cycles -> timeState 0,1,2,3,4,5,6, then 0 with timeout=1 for one cycle; mode stays 0.
- decodedInstruction=6'h12, decodedAddress=4'h5, getInstruction at T2 -> next cycle currentInstruction=6'h12, currentAddress=4'h5, mode=0, T0. Then endAddressing at T3 -> mode=1, T0.
- irq=1, irqMask=0, getInstruction in mode 1 -> mode=2, currentInstruction=6'h3F, intSource=0. Repeat with irqMask=1 -> mode=0, decoded codes loaded.
- nmi pulsed 1 cycle while rdy=0 at T3 -> state held; later getInstruction -> mode=2, intSource=1, nmiPend cleared. Next getInstruction -> mode=0, and no second interrupt.
- rdy=0 for 4 cycles at T4 with getInstruction asserted -> timeState stays 4, codes unchanged; rdy=1 -> transition occurs on the next edge.
- rst=1 asserted during mode 2, T3 with nmiPend set -> all outputs return to reset values next cycle; no interrupt taken afterwards without a new nmi edge.
